// File: rtl/data_mem_responder.sv
// Data-memory responder for the RV32I core: byte/half/word loads and stores on a
// 512-byte array, one-cycle registered read, saturating access counters, sticky error flag.
module data_mem_responder #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 9,
   parameter int DEPTH_WORDS = 128
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rd,
   input  logic              wr,
   input  logic [ADDR_W-1:0] addr,
   input  logic [2:0]        funct3,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              access_err,
   output logic [15:0]       rd_count,
   output logic [15:0]       wr_count
);

   localparam int IDX_W = ADDR_W - 2;

   logic [DATA_W-1:0] mem [DEPTH_WORDS];

   logic [IDX_W-1:0]  idx;
   logic [1:0]        lane;
   logic [4:0]        sh_amt;
   logic [DATA_W-1:0] cur_word;
   logic [DATA_W-1:0] lane_data;
   logic [DATA_W-1:0] ld_val;
   logic [DATA_W-1:0] wr_mask;
   logic [DATA_W-1:0] new_word;
   logic              aligned;
   logic              ld_size_ok;
   logic              st_size_ok;
   logic              ld_ok;
   logic              st_ok;

   assign idx       = addr[ADDR_W-1:2];
   assign lane      = addr[1:0];
   assign sh_amt    = {lane, 3'b000};
   assign cur_word  = mem[idx];
   assign lane_data = cur_word >> sh_amt;

   always_comb begin
      aligned = 1'b0;
      case (funct3[1:0])
         2'b00:   aligned = 1'b1;
         2'b01:   aligned = ~addr[0];
         2'b10:   aligned = (lane == 2'b00);
         default: aligned = 1'b0;
      endcase
   end

   // 011, 110 and 111 are not loads; only 000..010 are stores
   assign ld_size_ok = (funct3 != 3'b011) && (funct3[2:1] != 2'b11);
   assign st_size_ok = ~funct3[2] && (funct3[1:0] != 2'b11);
   assign ld_ok      = ld_size_ok && aligned;
   assign st_ok      = st_size_ok && aligned;

   always_comb begin
      ld_val = '0;
      case (funct3)
         3'b000:  ld_val = {{(DATA_W-8){lane_data[7]}}, lane_data[7:0]};
         3'b001:  ld_val = {{(DATA_W-16){lane_data[15]}}, lane_data[15:0]};
         3'b010:  ld_val = cur_word;
         3'b100:  ld_val = {{(DATA_W-8){1'b0}}, lane_data[7:0]};
         3'b101:  ld_val = {{(DATA_W-16){1'b0}}, lane_data[15:0]};
         default: ld_val = '0;
      endcase
   end

   always_comb begin
      wr_mask = '0;
      case (funct3[1:0])
         2'b00:   wr_mask = {{(DATA_W-8){1'b0}}, 8'hFF} << sh_amt;
         2'b01:   wr_mask = {{(DATA_W-16){1'b0}}, 16'hFFFF} << sh_amt;
         2'b10:   wr_mask = '1;
         default: wr_mask = '0;
      endcase
   end

   assign new_word = (cur_word & ~wr_mask) | ((wr_data << sh_amt) & wr_mask);

   // load samples cur_word before the same-edge store lands (read-before-write)
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
         rd_data    <= '0;
         rd_valid   <= 1'b0;
         access_err <= 1'b0;
         rd_count   <= '0;
         wr_count   <= '0;
      end else begin
         rd_valid <= rd;
         if (rd) begin
            rd_data <= ld_ok ? ld_val : '0;
            if (ld_ok && rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
         end
         if (wr && st_ok) begin
            mem[idx] <= new_word;
            if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
         end
         if ((rd && !ld_ok) || (wr && !st_ok)) access_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed test-plan cases plus random
// traffic against a byte-array reference model.
module tb_data_mem_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        rd, wr;
   logic [8:0]  addr;
   logic [2:0]  funct3;
   logic [31:0] wr_data;
   logic [31:0] rd_data;
   logic        rd_valid, access_err;
   logic [15:0] rd_count, wr_count;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0]  ref_mem [512];
   logic [31:0] exp_rd_data;
   logic        exp_rd_valid;
   logic        exp_err;
   int          exp_rc, exp_wc;

   data_mem_responder dut (
      .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .funct3(funct3),
      .wr_data(wr_data), .rd_data(rd_data), .rd_valid(rd_valid),
      .access_err(access_err), .rd_count(rd_count), .wr_count(wr_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
      end
   endtask

   function automatic bit aligned_ok(input logic [2:0] f, input logic [8:0] a);
      int sz = 1 << f[1:0];
      if (f[1:0] == 2'b11) return 1'b0;
      return (a % sz) == 0;
   endfunction

   function automatic bit ld_legal(input logic [2:0] f, input logic [8:0] a);
      return (f inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) && aligned_ok(f, a);
   endfunction

   function automatic bit st_legal(input logic [2:0] f, input logic [8:0] a);
      return (f inside {3'b000, 3'b001, 3'b010}) && aligned_ok(f, a);
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] f, input logic [8:0] a);
      logic [7:0]  b;
      logic [15:0] h;
      b = ref_mem[a];
      h = {ref_mem[(a + 1) % 512], ref_mem[a]};
      case (f)
         3'b000:  return {{24{b[7]}}, b};
         3'b001:  return {{16{h[15]}}, h};
         3'b010:  return {ref_mem[a + 3], ref_mem[a + 2], ref_mem[a + 1], ref_mem[a]};
         3'b100:  return {24'h0, b};
         3'b101:  return {16'h0, h};
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 512; i++) ref_mem[i] = 8'h00;
      exp_rd_data = 0; exp_rd_valid = 0; exp_err = 0; exp_rc = 0; exp_wc = 0;
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, ".valid"}, {31'h0, rd_valid}, {31'h0, exp_rd_valid});
      chk({tag, ".data"}, rd_data, exp_rd_data);
      chk({tag, ".err"}, {31'h0, access_err}, {31'h0, exp_err});
      chk({tag, ".rc"}, {16'h0, rd_count}, exp_rc);
      chk({tag, ".wc"}, {16'h0, wr_count}, exp_wc);
   endtask

   // one request cycle: predict, drive, clock, compare
   task automatic op(input string tag, input logic r, input logic w, input logic [8:0] a,
                     input logic [2:0] f, input logic [31:0] d);
      bit lok = ld_legal(f, a);
      bit sok = st_legal(f, a);
      exp_rd_valid = r;
      if (r) begin
         exp_rd_data = lok ? ref_load(f, a) : 32'h0;
         if (lok && exp_rc < 16'hFFFF) exp_rc++;
      end
      if (w && sok) begin
         for (int k = 0; k < (1 << f[1:0]); k++) ref_mem[a + k] = d[8*k +: 8];
         if (exp_wc < 16'hFFFF) exp_wc++;
      end
      if ((r && !lok) || (w && !sok)) exp_err = 1'b1;
      rd = r; wr = w; addr = a; funct3 = f; wr_data = d;
      @(posedge clk); #1;
      rd = 0; wr = 0;
      check_outputs(tag);
   endtask

   task automatic do_reset();
      reset = 1; rd = 1; wr = 0; addr = 0; funct3 = 3'b010; wr_data = 0;
      repeat (2) @(posedge clk);
      #1;
      model_clear();
      check_outputs("reset");
      reset = 0; rd = 0;
   endtask

   int rc_before, wc_before;

   initial begin
      reset = 1; rd = 0; wr = 0; addr = 0; funct3 = 0; wr_data = 0;
      model_clear();
      do_reset();
      op("lw0", 1, 0, 9'h000, 3'b010, 0);
      chk("lw0_const", rd_data, 32'h0000_0000);

      op("sw4", 0, 1, 9'h004, 3'b010, 32'h8000_00F1);
      op("lw4", 1, 0, 9'h004, 3'b010, 0);
      chk("lw4_const", rd_data, 32'h8000_00F1);
      op("lb4", 1, 0, 9'h004, 3'b000, 0);
      chk("lb4_const", rd_data, 32'hFFFF_FFF1);
      op("lbu4", 1, 0, 9'h004, 3'b100, 0);
      chk("lbu4_const", rd_data, 32'h0000_00F1);
      op("lh6", 1, 0, 9'h006, 3'b001, 0);
      chk("lh6_const", rd_data, 32'hFFFF_8000);
      op("lhu6", 1, 0, 9'h006, 3'b101, 0);
      chk("lhu6_const", rd_data, 32'h0000_8000);

      op("sw10", 0, 1, 9'h010, 3'b010, 32'h1122_3344);
      op("sb12", 0, 1, 9'h012, 3'b000, 32'h0000_00AA);
      op("sh10", 0, 1, 9'h010, 3'b001, 32'h0000_BEEF);
      op("lw10", 1, 0, 9'h010, 3'b010, 0);
      chk("merge_const", rd_data, 32'h11AA_BEEF);

      op("sw20", 0, 1, 9'h020, 3'b010, 32'h1234_5678);
      op("rw20", 1, 1, 9'h020, 3'b010, 32'hCAFE_BABE);
      chk("rbw_const", rd_data, 32'h1234_5678);
      op("lw20", 1, 0, 9'h020, 3'b010, 0);
      chk("rbw_new_const", rd_data, 32'hCAFE_BABE);

      rc_before = exp_rc; wc_before = exp_wc;
      op("lw2_mis", 1, 0, 9'h002, 3'b010, 0);
      chk("mis_data", rd_data, 32'h0);
      chk("mis_err", {31'h0, access_err}, 32'h1);
      op("sh31_mis", 0, 1, 9'h031, 3'b001, 32'h0000_FFFF);
      op("f011", 1, 0, 9'h040, 3'b011, 0);
      chk("rc_unch", {16'h0, rd_count}, rc_before);
      chk("wc_unch", {16'h0, wr_count}, wc_before);
      op("lw30", 1, 0, 9'h030, 3'b010, 0);
      chk("sh31_nowrite", rd_data, 32'h0);
      op("idle", 0, 0, 9'h000, 3'b000, 0);
      chk("err_sticky", {31'h0, access_err}, 32'h1);

      for (int i = 0; i < 400; i++) begin
         logic [8:0] a;
         a = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 511)) : 9'($urandom_range(0, 47));
         if (i == 200) do_reset();
         op("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a,
            3'($urandom_range(0, 7)), $urandom());
      end

      // in-flight load followed by reset must be dropped
      rd = 1; addr = 9'h004; funct3 = 3'b010;
      @(posedge clk); #1;
      do_reset();

      for (int i = 0; i < 65540; i++) begin
         op("sat", 1, 0, 9'(4 * $urandom_range(0, 127)), 3'b010, 0);
      end
      chk("rc_sat", {16'h0, rd_count}, 32'h0000_FFFF);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
